// File: rtl/sram_arb_pkg.sv
// Shared encodings for the two-port SRAM arbiter: FSM states, strobe patterns,
// default latencies and port indices.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_WR_LATENCY = 1;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_SEC = 1'b1;

    // Strobe bundle order: {cs, oe, wr, ub_b, lb_b}, all active-low
    localparam logic [4:0] STRB_IDLE  = 5'b11111;
    localparam logic [4:0] STRB_READ  = 5'b00100;
    localparam logic [4:0] STRB_WRITE = 5'b01000;

    function automatic logic [1:0] port_mask(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin pick; last_grant remembers the most recent winner so a
// tie always goes to the other port.
module sram_rr_arbiter
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_vld,
    output logic       grant_port
);

    logic last_grant;

    always_comb begin
        grant_vld  = grant_en && (req != 2'b00);
        grant_port = PORT_CPU;
        if (req == 2'b11) begin
            grant_port = ~last_grant;
        end else if (req[1]) begin
            grant_port = PORT_SEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_SEC;
        end else if (grant_vld) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port asynchronous-SRAM controller: round-robin grant, read, full write
// and read-modify-write for partial byte enables, with registered strobes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_LATENCY = DEF_WR_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_rd,
    input  logic [1:0]  req_wr,
    input  logic [18:0] req_addr0,
    input  logic [18:0] req_addr1,
    input  logic [3:0]  req_be0,
    input  logic [3:0]  req_be1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [31:0] rdata,
    output logic [1:0]  rdy,
    output logic        ram_cs,
    output logic        ram_oe,
    output logic        ram_wr,
    output logic        ram_ub_b,
    output logic        ram_lb_b,
    output logic [18:0] ram_addr,
    output logic [31:0] ram_dout,
    output logic        ram_dout_oe,
    input  logic [31:0] ram_din
);

    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);
    localparam logic [2:0] WR_LAT = 3'(WR_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  lcount_q, lcount_d;
    logic        port_q, port_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  strb_q, strb_d;
    logic [31:0] rdata_d;
    logic [1:0]  rdy_d;
    logic [18:0] addr_d;
    logic [31:0] dout_d;
    logic        dout_oe_d;

    logic [1:0]  req;
    logic        grant_vld;
    logic        grant_port;
    logic [18:0] sel_addr;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        sel_rd;

    function automatic logic [31:0] byte_merge(input logic [3:0]  be,
                                               input logic [31:0] wd,
                                               input logic [31:0] rd);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? wd[8*i +: 8] : rd[8*i +: 8];
        end
        return m;
    endfunction

    assign req       = req_rd | req_wr;
    assign sel_addr  = grant_port ? req_addr1  : req_addr0;
    assign sel_be    = grant_port ? req_be1    : req_be0;
    assign sel_wdata = grant_port ? req_wdata1 : req_wdata0;
    assign sel_rd    = grant_port ? req_rd[1]  : req_rd[0];

    assign {ram_cs, ram_oe, ram_wr, ram_ub_b, ram_lb_b} = strb_q;

    sram_rr_arbiter u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant_en   (state_q == IDLE),
        .grant_vld  (grant_vld),
        .grant_port (grant_port)
    );

    always_comb begin
        state_d   = state_q;
        lcount_d  = lcount_q;
        port_d    = port_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata;
        rdy_d     = 2'b00;
        addr_d    = ram_addr;
        dout_d    = ram_dout;
        dout_oe_d = ram_dout_oe;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    port_d  = grant_port;
                    be_d    = sel_be;
                    wdata_d = sel_wdata;
                    if (sel_rd) begin
                        strb_d   = STRB_READ;
                        addr_d   = sel_addr;
                        lcount_d = RD_LAT;
                        state_d  = READ;
                    end else if (sel_be == 4'hF) begin
                        strb_d    = STRB_WRITE;
                        addr_d    = sel_addr;
                        dout_d    = sel_wdata;
                        dout_oe_d = 1'b1;
                        lcount_d  = WR_LAT;
                        state_d   = WRITE;
                    end else if (sel_be != 4'h0) begin
                        strb_d   = STRB_READ;
                        addr_d   = sel_addr;
                        lcount_d = RD_LAT;
                        state_d  = RMW_RD;
                    end else begin
                        // Empty write: pass through WRITE with no strobes so rdy lands one cycle later
                        lcount_d = 3'd0;
                        state_d  = WRITE;
                    end
                end
            end
            READ: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    rdata_d = ram_din;
                    strb_d  = STRB_IDLE;
                    rdy_d   = port_mask(port_q);
                    state_d = DONE;
                end
            end
            RMW_RD: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    // oe releases on the same edge dout_oe rises, so the bus never fights
                    dout_d    = byte_merge(be_q, wdata_q, ram_din);
                    dout_oe_d = 1'b1;
                    strb_d    = STRB_WRITE;
                    lcount_d  = WR_LAT;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (lcount_q != 3'd0) begin
                    lcount_d = lcount_q - 3'd1;
                end else begin
                    strb_d    = STRB_IDLE;
                    dout_oe_d = 1'b0;
                    rdy_d     = port_mask(port_q);
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                strb_d    = STRB_IDLE;
                dout_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lcount_q    <= 3'd0;
            strb_q      <= STRB_IDLE;
            rdata       <= 32'h0;
            rdy         <= 2'b00;
            ram_addr    <= 19'h0;
            ram_dout    <= 32'h0;
            ram_dout_oe <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcount_q    <= lcount_d;
            strb_q      <= strb_d;
            rdata       <= rdata_d;
            rdy         <= rdy_d;
            ram_addr    <= addr_d;
            ram_dout    <= dout_d;
            ram_dout_oe <= dout_oe_d;
        end
    end

    always_ff @(posedge clk) begin
        port_q  <= port_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end

endmodule
